mem_dp_model: RTL and testbench

Parametrised dual-port synchronous memory model: a read-only instruction port (I) and a byte-strobed read/write data port (D) share one word array. It serves fetch and load/store traffic in the RV32I core simulation and FPGA prototypes. Depth, width and read latency are configurable, and out-of-range accesses are flagged. Same-address I-read / D-write collisions follow a defined rule.

---
 rtl/mem_dp_pkg.sv | 17 +
 rtl/mem_dp_rsp_pipe.sv | 43 ++++
 rtl/mem_dp_model.sv | 127 ++++++++++++
 tb/tb_mem_dp_model.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dp_pkg.sv
// Shared types and constants for the dual-port memory model.
package mem_dp_pkg;

  localparam int RD_LATENCY_MAX = 4;

  localparam logic RSP_ERR_NONE  = 1'b0;
  localparam logic RSP_ERR_RANGE = 1'b1;

  typedef struct packed {
    logic vld;
    logic err;
    logic is_write;
  } rsp_stage_t;

  localparam rsp_stage_t RSP_STAGE_IDLE = '{vld: 1'b0, err: RSP_ERR_NONE, is_write: 1'b0};

endpackage

// File: rtl/mem_dp_rsp_pipe.sv
// Per-port response delay line: control flags and read data delayed RD_LATENCY edges.
module mem_dp_rsp_pipe
  import mem_dp_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  rsp_stage_t            req_stage,
  input  logic [DATA_WIDTH-1:0] req_data,
  output rsp_stage_t            rsp_stage,
  output logic [DATA_WIDTH-1:0] rsp_data
);

  rsp_stage_t            stage_r [RD_LATENCY];
  logic [DATA_WIDTH-1:0] data_r  [RD_LATENCY];

  // Shift flags every edge; data stages only load on read responses so the tail holds its last value.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        stage_r[i] <= RSP_STAGE_IDLE;
        data_r[i]  <= '0;
      end
    end else begin
      stage_r[0] <= req_stage;
      if (req_stage.vld && !req_stage.is_write) begin
        data_r[0] <= req_data;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        stage_r[i] <= stage_r[i-1];
        if (stage_r[i-1].vld && !stage_r[i-1].is_write) begin
          data_r[i] <= data_r[i-1];
        end
      end
    end
  end

  assign rsp_stage = stage_r[RD_LATENCY-1];
  assign rsp_data  = data_r[RD_LATENCY-1];

endmodule

// File: rtl/mem_dp_model.sv
// Dual-port word memory: read-only I port, byte-strobed D port, range-checked accesses.
// Define MEM_DP_WR_FWD_EN to make same-address I reads see the concurrent D write (write-first).
module mem_dp_model
  import mem_dp_pkg::*;
#(
  parameter int BYTE_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 1024,
  parameter int ADDR_WIDTH = $clog2(DATA_DEPTH),
  parameter int STRB_WIDTH = DATA_WIDTH / BYTE_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  i_en,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_rvld,
  output logic                  i_rerr,
  input  logic                  d_en,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [STRB_WIDTH-1:0] d_wen,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_rvld,
  output logic                  d_bvld,
  output logic                  d_rerr
);

  // One extra bit so a depth equal to 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [STRB_WIDTH-1:0] wen
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int n = 0; n < STRB_WIDTH; n++) begin
      if (wen[n]) begin
        res[n*BYTE_WIDTH +: BYTE_WIDTH] = new_word[n*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [DATA_DEPTH];

  logic                  i_in_range_s;
  logic                  d_in_range_s;
  logic                  d_is_write_s;
  logic                  d_wr_s;
  logic [DATA_WIDTH-1:0] i_rd_word_s;
  logic [DATA_WIDTH-1:0] d_rd_word_s;
  rsp_stage_t            i_req_s;
  rsp_stage_t            d_req_s;
  rsp_stage_t            i_rsp_s;
  rsp_stage_t            d_rsp_s;

  // Address decode, read-word selection and request tagging.
  always_comb begin
    i_in_range_s = ({1'b0, i_addr} < DEPTH_LIM);
    d_in_range_s = ({1'b0, d_addr} < DEPTH_LIM);
    d_is_write_s = |d_wen;
    d_wr_s       = d_en && d_is_write_s && d_in_range_s;

    if (!i_in_range_s) begin
      i_rd_word_s = '0;
    end
`ifdef MEM_DP_WR_FWD_EN
    else if (d_wr_s && (i_addr == d_addr)) begin
      i_rd_word_s = merge_lanes(mem_r[i_addr], d_wdata, d_wen);
    end
`endif
    else begin
      i_rd_word_s = mem_r[i_addr];
    end

    if (d_in_range_s) begin
      d_rd_word_s = mem_r[d_addr];
    end else begin
      d_rd_word_s = '0;
    end

    i_req_s = '{vld: i_en, err: i_en && !i_in_range_s, is_write: 1'b0};
    d_req_s = '{vld: d_en, err: d_en && !d_in_range_s, is_write: d_en && d_is_write_s};
  end

  // Array update; the non-blocking write gives read-first behaviour to same-edge reads.
  always_ff @(posedge CLK) begin
    if (d_wr_s) begin
      mem_r[d_addr] <= merge_lanes(mem_r[d_addr], d_wdata, d_wen);
    end
  end

  mem_dp_rsp_pipe #(
    .RD_LATENCY (RD_LATENCY),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_i_pipe (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .req_stage (i_req_s),
    .req_data  (i_rd_word_s),
    .rsp_stage (i_rsp_s),
    .rsp_data  (i_rdata)
  );

  mem_dp_rsp_pipe #(
    .RD_LATENCY (RD_LATENCY),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_d_pipe (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .req_stage (d_req_s),
    .req_data  (d_rd_word_s),
    .rsp_stage (d_rsp_s),
    .rsp_data  (d_rdata)
  );

  assign i_rvld = i_rsp_s.vld && !i_rsp_s.is_write;
  assign i_rerr = i_rsp_s.vld && i_rsp_s.err;
  assign d_rvld = d_rsp_s.vld && !d_rsp_s.is_write;
  assign d_bvld = d_rsp_s.vld && d_rsp_s.is_write;
  assign d_rerr = d_rsp_s.vld && d_rsp_s.err;

endmodule

// File: tb/tb_mem_dp_model.sv
// Directed bench: three instances (RD_LATENCY 1/3/4, DATA_DEPTH 1000) share one stimulus stream.
module tb_mem_dp_model;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        i_en;
  logic [9:0]  i_addr;
  logic        d_en;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wen;

  logic [31:0] i_rdata_o [3];
  logic [31:0] d_rdata_o [3];
  logic        i_rvld_o  [3];
  logic        i_rerr_o  [3];
  logic        d_rvld_o  [3];
  logic        d_bvld_o  [3];
  logic        d_rerr_o  [3];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_dp_model #(
      .DATA_DEPTH (1000),
      .RD_LATENCY ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .CLK     (CLK),
      .RSTN    (RSTN),
      .i_en    (i_en),
      .i_addr  (i_addr),
      .i_rdata (i_rdata_o[g]),
      .i_rvld  (i_rvld_o[g]),
      .i_rerr  (i_rerr_o[g]),
      .d_en    (d_en),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_wen   (d_wen),
      .d_rdata (d_rdata_o[g]),
      .d_rvld  (d_rvld_o[g]),
      .d_bvld  (d_bvld_o[g]),
      .d_rerr  (d_rerr_o[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic d_req(input logic [9:0] a, input logic [31:0] wd, input logic [3:0] we);
    d_en    = 1'b1;
    d_addr  = a;
    d_wdata = wd;
    d_wen   = we;
  endtask

  task automatic idle();
    i_en  = 1'b0;
    d_en  = 1'b0;
    d_wen = 4'h0;
  endtask

  logic [31:0] l3_data [3];
  logic [31:0] col_exp;
  logic        seen_rvld;

  initial begin
    RSTN    = 1'b0;
    i_addr  = 10'd0;
    d_addr  = 10'd0;
    d_wdata = 32'h0;
    idle();
    l3_data[0] = 32'hA0A0_A0A0;
    l3_data[1] = 32'hA1A1_A1A1;
    l3_data[2] = 32'hA2A2_A2A2;
`ifdef MEM_DP_WR_FWD_EN
    col_exp = 32'hCAFE_F00D;
`else
    col_exp = 32'h0000_0000;
`endif
    repeat (2) step();

    for (int g = 0; g < 3; g++) begin
      check("rst_i_rdata", i_rdata_o[g], 32'h0);
      check("rst_i_rvld",  i_rvld_o[g],  32'h0);
      check("rst_i_rerr",  i_rerr_o[g],  32'h0);
      check("rst_d_rdata", d_rdata_o[g], 32'h0);
      check("rst_d_rvld",  d_rvld_o[g],  32'h0);
      check("rst_d_bvld",  d_bvld_o[g],  32'h0);
      check("rst_d_rerr",  d_rerr_o[g],  32'h0);
    end
    RSTN = 1'b1;
    step();

    // full-word write then read back
    d_req(10'd5, 32'hDEAD_BEEF, 4'hF);
    step();
    check("wr_bvld", d_bvld_o[0], 32'h1);
    check("wr_rvld", d_rvld_o[0], 32'h0);
    check("wr_rerr", d_rerr_o[0], 32'h0);
    d_req(10'd5, 32'h0, 4'h0);
    step();
    check("rd_rvld", d_rvld_o[0], 32'h1);
    check("rd_bvld", d_bvld_o[0], 32'h0);
    check("rd_data", d_rdata_o[0], 32'hDEAD_BEEF);
    check("rd_rerr", d_rerr_o[0], 32'h0);
    idle();
    step();
    check("hold_rvld", d_rvld_o[0], 32'h0);
    check("hold_data", d_rdata_o[0], 32'hDEAD_BEEF);

    // byte strobes
    d_req(10'd7, 32'h1122_3344, 4'hF);
    step();
    d_req(10'd7, 32'hAABB_CCDD, 4'b0101);
    step();
    d_req(10'd7, 32'h0, 4'h0);
    step();
    check("strb_data", d_rdata_o[0], 32'h11BB_33DD);

    // same-address I read / D write
    d_req(10'd9, 32'h0, 4'hF);
    step();
    i_en   = 1'b1;
    i_addr = 10'd9;
    d_req(10'd9, 32'hCAFE_F00D, 4'hF);
    step();
    check("col_i_rvld", i_rvld_o[0],  32'h1);
    check("col_i_data", i_rdata_o[0], col_exp);
    check("col_d_bvld", d_bvld_o[0],  32'h1);
    i_en = 1'b0;
    d_req(10'd9, 32'h0, 4'h0);
    step();
    check("col_d_data", d_rdata_o[0], 32'hCAFE_F00D);

    // out-of-range accesses
    d_req(10'd999, 32'h1234_5678, 4'hF);
    step();
    d_req(10'd1000, 32'hFFFF_FFFF, 4'hF);
    i_en   = 1'b1;
    i_addr = 10'd1000;
    step();
    check("oor_wr_bvld", d_bvld_o[0],  32'h1);
    check("oor_wr_rerr", d_rerr_o[0],  32'h1);
    check("oor_i_rvld",  i_rvld_o[0],  32'h1);
    check("oor_i_rerr",  i_rerr_o[0],  32'h1);
    check("oor_i_data",  i_rdata_o[0], 32'h0);
    i_en = 1'b0;
    d_req(10'd1000, 32'h0, 4'h0);
    step();
    check("oor_rd_rvld", d_rvld_o[0],  32'h1);
    check("oor_rd_rerr", d_rerr_o[0],  32'h1);
    check("oor_rd_data", d_rdata_o[0], 32'h0);
    d_req(10'd999, 32'h0, 4'h0);
    step();
    check("oor_999_data", d_rdata_o[0], 32'h1234_5678);
    check("oor_999_rerr", d_rerr_o[0],  32'h0);

    // back-to-back I reads through latency 1 and 3
    for (int a = 0; a < 3; a++) begin
      d_req(10'(a), l3_data[a], 4'hF);
      step();
    end
    idle();
    repeat (5) step();
    for (int s = 1; s <= 6; s++) begin
      if (s <= 3) begin
        i_en   = 1'b1;
        i_addr = 10'(s - 1);
      end else begin
        i_en = 1'b0;
      end
      step();
      check("l3_rvld", i_rvld_o[1], (s >= 3 && s <= 5) ? 32'h1 : 32'h0);
      if (s >= 3 && s <= 5) check("l3_data", i_rdata_o[1], l3_data[s-3]);
      check("l1_rvld", i_rvld_o[0], (s <= 3) ? 32'h1 : 32'h0);
      if (s <= 3) check("l1_data", i_rdata_o[0], l3_data[s-1]);
    end

    // reset in flight on latency 4 flushes the pending read
    repeat (5) step();
    d_req(10'd1, 32'h0, 4'h0);
    step();
    idle();
    step();
    RSTN = 1'b0;
    #1;
    check("mid_rst_i_rdata", i_rdata_o[2], 32'h0);
    check("mid_rst_i_rvld",  i_rvld_o[2],  32'h0);
    check("mid_rst_i_rerr",  i_rerr_o[2],  32'h0);
    check("mid_rst_d_rdata", d_rdata_o[2], 32'h0);
    check("mid_rst_d_rvld",  d_rvld_o[2],  32'h0);
    check("mid_rst_d_bvld",  d_bvld_o[2],  32'h0);
    check("mid_rst_d_rerr",  d_rerr_o[2],  32'h0);
    step();
    RSTN = 1'b1;
    seen_rvld = 1'b0;
    for (int s = 0; s < 6; s++) begin
      step();
      seen_rvld = seen_rvld | d_rvld_o[2];
    end
    check("rst_flush_rvld", seen_rvld, 32'h0);

    // array contents survive reset
    d_req(10'd7, 32'h0, 4'h0);
    step();
    check("post_rst_data", d_rdata_o[0], 32'h11BB_33DD);
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
